intra_wavefront_scheduler: RTL and testbench
============================================

INTRA_WAVEFRONT_SCHEDULER -- requirements
Module: intra_wavefront_scheduler

Interface
REQ-001 Parameters SHALL be: WIDTH, default 1280, frame width in pixels; LENGTH, default 720, frame height in pixels; BLK, default 4, block edge in pixels.
REQ-002 WIDTH/BLK (COLS) and LENGTH/BLK (ROWS) SHALL be integers with COLS >= 2 and ROWS >= 2; other values are unsupported.
REQ-003 Ports SHALL be, clock and reset first:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits new block issues.
- e0_start  output  1  one-cycle issue strobe to engine 0 (even block rows).
- e0_blk_x  output  16  engine 0 block pixel column, col*BLK.
- e0_blk_y  output  16  engine 0 block pixel row, row*BLK.
- e0_done  input  1  one-cycle completion pulse from engine 0.
- e1_start, e1_blk_x, e1_blk_y, e1_done: as above, for engine 1 (odd block rows).
- busy  output  1  high while either engine is in BUSY.
- frame_done  output  1  sticky; high once both engines are FINISHED.

Function
REQ-004 Each engine SHALL have an independent FSM with states IDLE, ISSUE, BUSY and FINISHED, plus registers row and col.
REQ-005 Engine 0 SHALL start at row 0 and engine 1 at row 1; each SHALL walk its rows left to right, col 0..COLS-1, and step its row by 2.
REQ-006 IDLE->ISSUE SHALL occur when enable=1 and dep_ok, both evaluated on registered state.
REQ-007 In ISSUE, start SHALL be high for exactly one cycle with blk_x=col*BLK and blk_y=row*BLK; the next state SHALL be BUSY.
REQ-008 blk_x/blk_y SHALL hold stable from ISSUE until the next ISSUE.
REQ-009 In BUSY, done=1 SHALL advance the engine:
- col<COLS-1: col+1, then IDLE.
- col=COLS-1: col=0 and row+2; if row+2>=ROWS, FINISHED, else IDLE.
REQ-010 dep_ok for an engine at (r,c), with the other engine's registers (orow,ocol), SHALL be true when any of:
- r=0;
- the other engine is FINISHED;
- orow>r-1;
- orow=r-1 and ocol>=c+2 (top and top-right blocks done).
For c=COLS-1 this SHALL resolve only through the row-advance term.
REQ-011 A done pulse in IDLE, ISSUE or FINISHED SHALL be ignored.
REQ-012 Both engines completing in the same cycle SHALL both be applied; each SHALL see the other's update on the following cycle.
REQ-013 Minimum issue-to-issue spacing per engine SHALL be 3 cycles: ISSUE, BUSY with done, IDLE.
REQ-014 enable=0 SHALL block only IDLE->ISSUE; ISSUE and BUSY progress and done handling SHALL continue.
REQ-015 busy SHALL be the OR of the two engines' BUSY states.
REQ-016 frame_done SHALL rise the cycle after the second engine enters FINISHED and SHALL stay high until reset.
REQ-017 Address arithmetic SHALL be 16-bit unsigned; row and col SHALL be 16-bit.

Reset
REQ-018 Reset asserted SHALL immediately, asynchronously, force:
- both FSMs to IDLE;
- engine 0 to row 0, col 0;
- engine 1 to row 1, col 0;
- all outputs to 0.
REQ-019 Reset mid-operation SHALL abandon in-flight blocks; a later done pulse SHALL be ignored, per REQ-011.
REQ-020 The first issue SHALL occur at the first rising edge after reset deasserts with enable=1.

Configuration
REQ-021 With macro INTRA_SCHED_STALL_CNT_EN defined, the block SHALL add output stall_cycles [31:0].
REQ-022 stall_cycles SHALL increment once per cycle in which either engine is IDLE with enable=1 and dep_ok=0 (saturating at all ones); reset SHALL clear it to 0.
REQ-023 Without INTRA_SCHED_STALL_CNT_EN, the stall_cycles port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 WIDTH=16, LENGTH=16, BLK=4; engines return done 3 cycles after start; enable=1 after reset:
- e0_start (0,0) on the 1st cycle;
- e1_start (0,4) only after e0 completes blocks x=0 and x=4;
- frame_done after 16 blocks.
REQ-025 Same setup with enable dropped while e0 is BUSY: that block's done is accepted, with no start while enable=0; issue resumes 1 cycle after enable=1.
REQ-026 Force e0_done and e1_done in the same cycle: both cols advance; the dependency update takes effect the next cycle.
REQ-027 Spurious e1_done while e1 is IDLE: no change in col/row; no start.
REQ-028 Assert reset while both engines are BUSY at row 2/3: outputs go to 0 immediately; restart issues e0 (0,0).
REQ-029 With INTRA_SCHED_STALL_CNT_EN: in the REQ-024 run, stall_cycles>0 once e1 has waited; a reset returns it to 0.

Source files
------------

// File: rtl/intra_wavefront_scheduler.sv
// Two-engine wavefront block issuer: engine 0 walks even block rows, engine 1 odd rows.
// Define INTRA_SCHED_STALL_CNT_EN to add the saturating stall_cycles counter output.
module intra_wavefront_scheduler #(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720,
  parameter int BLK    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        e0_start,
  output logic [15:0] e0_blk_x,
  output logic [15:0] e0_blk_y,
  input  logic        e0_done,
  output logic        e1_start,
  output logic [15:0] e1_blk_x,
  output logic [15:0] e1_blk_y,
  input  logic        e1_done,
  output logic        busy,
  output logic        frame_done
`ifdef INTRA_SCHED_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int COLS = WIDTH / BLK;
  localparam int ROWS = LENGTH / BLK;

  localparam logic [15:0] LAST_COL = 16'(COLS - 1);
  localparam logic [16:0] ROWS17   = 17'(ROWS);
  localparam logic [15:0] BLK16    = 16'(BLK);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] BUSY     = 2'd2;
  localparam logic [1:0] FINISHED = 2'd3;

  logic [1:0]  st [2];
  logic [15:0] rw [2];
  logic [15:0] cl [2];
  logic [15:0] bx [2];
  logic [15:0] by [2];
  logic        done_w [2];
`ifdef INTRA_SCHED_STALL_CNT_EN
  logic        stall_w [2];
`endif

  assign done_w[0] = e0_done;
  assign done_w[1] = e1_done;

  for (genvar g = 0; g < 2; g++) begin : g_eng
    localparam int O = 1 - g;

    logic [1:0]  state_q, state_d;
    logic [15:0] row_q, row_d;
    logic [15:0] col_q, col_d;
    logic [15:0] bx_q, bx_d;
    logic [15:0] by_q, by_d;
    logic        dep_ok;

    // Top and top-right neighbours live in the other engine's row above.
    always_comb begin
      dep_ok = (row_q == 16'd0)
            || (st[O] == FINISHED)
            || ({1'b0, rw[O]} + 17'd1 > {1'b0, row_q})
            || ((rw[O] + 16'd1 == row_q)
                && ({1'b0, cl[O]} >= {1'b0, col_q} + 17'd2));
    end

    always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      bx_d    = bx_q;
      by_d    = by_q;
      case (state_q)
        IDLE: begin
          if (enable && dep_ok) begin
            state_d = ISSUE;
            bx_d    = col_q * BLK16;
            by_d    = row_q * BLK16;
          end
        end
        ISSUE: state_d = BUSY;
        BUSY: begin
          if (done_w[g]) begin
            if (col_q < LAST_COL) begin
              col_d   = col_q + 16'd1;
              state_d = IDLE;
            end else begin
              col_d   = 16'd0;
              row_d   = row_q + 16'd2;
              if ({1'b0, row_q} + 17'd2 >= ROWS17) state_d = FINISHED;
              else state_d = IDLE;
            end
          end
        end
        FINISHED: state_d = FINISHED;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        row_q   <= 16'(g);
        col_q   <= 16'd0;
        bx_q    <= 16'd0;
        by_q    <= 16'd0;
      end else begin
        state_q <= state_d;
        row_q   <= row_d;
        col_q   <= col_d;
        bx_q    <= bx_d;
        by_q    <= by_d;
      end
    end

    assign st[g] = state_q;
    assign rw[g] = row_q;
    assign cl[g] = col_q;
    assign bx[g] = bx_q;
    assign by[g] = by_q;
`ifdef INTRA_SCHED_STALL_CNT_EN
    assign stall_w[g] = (state_q == IDLE) && enable && !dep_ok;
`endif
  end

  logic frame_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done_q <= 1'b0;
    else if (st[0] == FINISHED && st[1] == FINISHED) frame_done_q <= 1'b1;
  end

  assign e0_start   = (st[0] == ISSUE);
  assign e1_start   = (st[1] == ISSUE);
  assign e0_blk_x   = bx[0];
  assign e0_blk_y   = by[0];
  assign e1_blk_x   = bx[1];
  assign e1_blk_y   = by[1];
  assign busy       = (st[0] == BUSY) || (st[1] == BUSY);
  assign frame_done = frame_done_q;

`ifdef INTRA_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= 32'd0;
    else if ((stall_w[0] || stall_w[1]) && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_intra_wavefront_scheduler.sv
// Self-checking bench for intra_wavefront_scheduler on a 16x16 frame, 4x4 blocks.
// Reference tracks completed blocks in a grid and derives readiness from neighbours.
module tb_intra_wavefront_scheduler;

  localparam int W    = 16;
  localparam int L    = 16;
  localparam int B    = 4;
  localparam int COLS = W / B;
  localparam int ROWS = L / B;

  localparam int PW = 0;
  localparam int PI = 1;
  localparam int PB = 2;
  localparam int PF = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        e0_done, e1_done;
  logic        e0_start, e1_start;
  logic [15:0] e0_blk_x, e0_blk_y, e1_blk_x, e1_blk_y;
  logic        busy, frame_done;
`ifdef INTRA_SCHED_STALL_CNT_EN
  logic [31:0] stall_cycles;
  int          mstall;
  logic [31:0] dut_stall11;
`endif

  always #5 clk = ~clk;

  intra_wavefront_scheduler #(.WIDTH(W), .LENGTH(L), .BLK(B)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .e0_start(e0_start),
    .e0_blk_x(e0_blk_x),
    .e0_blk_y(e0_blk_y),
    .e0_done(e0_done),
    .e1_start(e1_start),
    .e1_blk_x(e1_blk_x),
    .e1_blk_y(e1_blk_y),
    .e1_done(e1_done),
    .busy(busy),
    .frame_done(frame_done)
`ifdef INTRA_SCHED_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  int ph [2];
  int nr [2];
  int nc [2];
  int mbx [2];
  int mby [2];
  int cnt [2];
  bit cmp [ROWS][COLS];
  bit mfd;

  int cyc;
  int nstarts;
  int first_e0, first_e1;
  int fe0x, fe0y;
  bit hit;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit rowfull(input int r);
    for (int c = 0; c < COLS; c++)
      if (!cmp[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  // Block (r,c) may start once its top and top-right neighbours are complete.
  function automatic bit mdep(input int e);
    int r, c;
    r = nr[e];
    c = nc[e];
    if (r == 0) return 1'b1;
    if (rowfull(r - 1)) return 1'b1;
    if (c + 1 < COLS && cmp[r-1][c] && cmp[r-1][c+1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mreset();
    for (int e = 0; e < 2; e++) begin
      ph[e]  = PW;
      nr[e]  = e;
      nc[e]  = 0;
      mbx[e] = 0;
      mby[e] = 0;
      cnt[e] = 0;
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cmp[r][c] = 1'b0;
    mfd = 1'b0;
`ifdef INTRA_SCHED_STALL_CNT_EN
    mstall = 0;
`endif
  endtask

  task automatic model_step(input bit en, input bit d0, input bit d1);
    bit dp [2];
    bit d [2];
    bit fdn;
    d[0] = d0;
    d[1] = d1;
    for (int e = 0; e < 2; e++)
      dp[e] = (ph[e] == PW) ? mdep(e) : 1'b0;
`ifdef INTRA_SCHED_STALL_CNT_EN
    if ((ph[0] == PW && en && !dp[0]) || (ph[1] == PW && en && !dp[1]))
      mstall++;
`endif
    fdn = mfd || (ph[0] == PF && ph[1] == PF);
    for (int e = 0; e < 2; e++) begin
      case (ph[e])
        PW: if (en && dp[e]) begin
          ph[e]  = PI;
          mbx[e] = nc[e] * B;
          mby[e] = nr[e] * B;
        end
        PI: ph[e] = PB;
        PB: if (d[e]) begin
          cmp[nr[e]][nc[e]] = 1'b1;
          nc[e]++;
          if (nc[e] == COLS) begin
            nc[e] = 0;
            nr[e] += 2;
            ph[e] = (nr[e] >= ROWS) ? PF : PW;
          end else begin
            ph[e] = PW;
          end
        end
        default: ;
      endcase
    end
    mfd = fdn;
  endtask

  task automatic compare_all();
    chk("e0_start", {31'd0, e0_start}, {31'd0, ph[0] == PI});
    chk("e1_start", {31'd0, e1_start}, {31'd0, ph[1] == PI});
    chk("e0_blk_x", {16'd0, e0_blk_x}, mbx[0]);
    chk("e0_blk_y", {16'd0, e0_blk_y}, mby[0]);
    chk("e1_blk_x", {16'd0, e1_blk_x}, mbx[1]);
    chk("e1_blk_y", {16'd0, e1_blk_y}, mby[1]);
    chk("busy", {31'd0, busy}, {31'd0, ph[0] == PB || ph[1] == PB});
    chk("frame_done", {31'd0, frame_done}, {31'd0, mfd});
`ifdef INTRA_SCHED_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, mstall);
`endif
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    e0_done = 1'b0;
    e1_done = 1'b0;
    mreset();
    first_e0 = -1;
    first_e1 = -1;
    nstarts  = 0;
    fe0x     = -1;
    fe0y     = -1;
`ifdef INTRA_SCHED_STALL_CNT_EN
    dut_stall11 = 32'hDEAD;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc = 0;
    compare_all();
    reset = 1'b0;
  endtask

  // Engines answer lmin..lmax cycles after start; hold cycles keep enable low
  // while pulsing stray dones that must be ignored.
  task automatic run(input int lmin, input int lmax, input int spur,
                     input int dis, input int hold, input bit stop23,
                     input int budget, output bit hit_o);
    bit en;
    bit d [2];
    bit stop;
    hit_o = 1'b0;
    stop  = 1'b0;
    for (int k = 1; k <= budget && !stop; k++) begin
      en = (k <= hold) ? 1'b0 : ($urandom_range(99) >= dis);
      for (int e = 0; e < 2; e++) begin
        d[e] = 1'b0;
        if (ph[e] == PI) cnt[e] = $urandom_range(lmax, lmin);
        else if (cnt[e] > 0) begin
          cnt[e]--;
          if (cnt[e] == 0) d[e] = 1'b1;
        end
        if (ph[e] != PB && cnt[e] == 0 && $urandom_range(99) < spur)
          d[e] = 1'b1;
        if (k <= hold) d[e] = 1'b1;
      end
      enable  = en;
      e0_done = d[0];
      e1_done = d[1];
      @(posedge clk);
      model_step(en, d[0], d[1]);
      @(negedge clk);
      cyc = k;
      compare_all();
      nstarts += int'(e0_start === 1'b1) + int'(e1_start === 1'b1);
      if (ph[0] == PI && first_e0 < 0) begin
        first_e0 = k;
        fe0x = mbx[0];
        fe0y = mby[0];
      end
      if (ph[1] == PI && first_e1 < 0) first_e1 = k;
`ifdef INTRA_SCHED_STALL_CNT_EN
      if (k == 11) dut_stall11 = stall_cycles;
`endif
      if (mfd) stop = 1'b1;
      if (stop23 && ph[0] == PB && ph[1] == PB && nr[0] == 2 && nr[1] == 3) begin
        hit_o = 1'b1;
        stop  = 1'b1;
      end
    end
    if (!stop) begin
      checks++;
      errors++;
      $display("FAIL timeout cyc %0d: got no finish expected finish within %0d",
               cyc, budget);
    end
    enable  = 1'b0;
    e0_done = 1'b0;
    e1_done = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    e0_done = 1'b0;
    e1_done = 1'b0;

    // Fixed 3-cycle engines, enable always high.
    do_reset();
    run(3, 3, 0, 0, 0, 1'b0, 400, hit);
    chk("pin_e0_first_cycle", first_e0, 1);
    chk("pin_e0_first_x", fe0x, 0);
    chk("pin_e0_first_y", fe0y, 0);
    chk("pin_e1_first_cycle", first_e1, 11);
    chk("pin_starts_at_frame_done", nstarts, 16);
    chk("pin_frame_done", {31'd0, frame_done}, 32'd1);
`ifdef INTRA_SCHED_STALL_CNT_EN
    chk("pin_stall_at_c11", dut_stall11, 32'd10);
`endif

    // Async reset while both engines are busy on rows 2 and 3.
    do_reset();
    run(3, 3, 0, 0, 0, 1'b1, 400, hit);
    chk("pin_busy_rows_2_3_reached", {31'd0, hit}, 32'd1);
    chk("pin_busy_before_reset", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_e0_start", {31'd0, e0_start}, 32'd0);
    chk("rst_e1_start", {31'd0, e1_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_e0_blk", {e0_blk_x, e0_blk_y}, 32'd0);
    chk("rst_e1_blk", {e1_blk_x, e1_blk_y}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef INTRA_SCHED_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    do_reset();
    run(3, 3, 0, 0, 3, 1'b0, 400, hit);
    chk("pin_restart_e0_cycle", first_e0, 4);
    chk("pin_restart_e0_x", fe0x, 0);
    chk("pin_restart_e0_y", fe0y, 0);
    chk("pin_restart_e1_cycle", first_e1, 14);
    chk("pin_restart_starts", nstarts, 16);

    // Random latency, stray dones and enable drops.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      run(1, 5, 15, 25, 0, 1'b0, 3000, hit);
      chk("rand_starts", nstarts, 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
